seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial bit-pattern detector. It samples one input bit per qualified clock and emits a one-cycle registered pulse each time the last PAT_W accepted bits equal PATTERN. Overlapping matches are selectable, and a saturating match counter is included. It replaces the fixed-pattern, single-mode serial detector FSM and sits directly on a serial bit stream ahead of any framing or control logic.

## Interface
- PAT_W, 4: pattern length in bits; legal range 1..32.
- PATTERN, 4'b1011: pattern to detect; bit PAT_W-1 is the first bit received.
- OVERLAP, 1: 1 = overlapping matches counted; 0 = search restarts from empty after each match.
- CNT_W, 8: width of the match counter.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ip  in  1  serial data bit.
- ip_valid  in  1  qualifies ip; when low the bit is ignored and the state is held.
- clr_count  in  1  synchronous clear of match_count only.
- op  out  1  match pulse, high for exactly one cycle per match.
- match_count  out  CNT_W  number of matches since reset or clear; saturates.
- state_o  out  $clog2(PAT_W+1)  current matched-prefix length; debug only.

## Operation
- State S = length of the longest prefix of PATTERN that is a suffix of the accepted bits; S ranges over 0..PAT_W-1.
- Accepted bit b (ip_valid=1):
  - If PATTERN[PAT_W-1-S] == b: next prefix length is S+1.
  - Otherwise: follow the failure chain (KMP) until a prefix extends with b, or the prefix length reaches 0.
- Reaching length PAT_W is a match. It sets op=1 next cycle and increments match_count.
- Next S after a match:
  - OVERLAP=1: fail(PAT_W), the longest proper prefix of PATTERN that is also a suffix.
  - OVERLAP=0: 0.
- ip_valid=0: S is held, op=0 next cycle, match_count is held.
- match_count saturates at 2^CNT_W-1; further matches still pulse op.
- clr_count=1 with a match in the same cycle: match_count becomes 1. The clear applies first, then the increment.
- Priority order: reset, then clr_count, then ip_valid.
- The reset value of every output is 0 (op, match_count, state_o).
- reset asserted mid-pattern discards the partial prefix; no match can complete in the reset cycle.
- PAT_W=1: every accepted bit equal to PATTERN[0] is a match, regardless of OVERLAP.

## Timing
- Latency: op rises on the clock edge that samples the final matching bit and is visible for the following cycle (1-cycle registered latency).
- Back-to-back matches on consecutive accepted bits (e.g., PATTERN=2'b11 with OVERLAP=1, input 1,1,1) give op high on consecutive cycles.
- No combinational path from any input to any output.
- Throughput: one bit per cycle; no stall or back-pressure.

## Structure
- Package seq_det_pkg holds:
  - elaboration-time function fail_len(pattern, len), returning the KMP failure length;
  - function next_state(pattern, pat_w, s, b), returning the next prefix length 0..PAT_W.
- The next-state logic is a constant-folded case over S and b. There is no runtime table RAM.
- Sub-module sat_counter (parameter W; ports clk, reset, clr, inc, count) implements match_count and is reused elsewhere.

## Test plan
- PATTERN=4'b1011, OVERLAP=1, stream 1,0,1,1,0,1,1 (ip_valid=1): op pulses after bits 4 and 7; match_count=2.
- Same stream, OVERLAP=0: op pulses after bit 4 only; match_count=1; state_o=1 after bit 7.
- PATTERN=4'b1011, stream 1,0,1 then ip_valid=0 for 3 cycles, then bit 1 with ip_valid=1: state_o holds 3 during the gap; op pulses after the final bit.
- reset=1 for one cycle after bits 1,0,1, then bit 1: op stays 0; state_o=1 (fresh prefix "1"); match_count=0.
- CNT_W=2, PATTERN=2'b11, OVERLAP=1, six consecutive 1s: op pulses 5 times; match_count saturates at 3. A following clr_count coincident with a match gives match_count=1.
- PAT_W=1, PATTERN=1'b0, stream 0,1,0,0: op pulses after bits 1, 3 and 4 for both OVERLAP values.

Source files
------------

// File: rtl/seq_detector_param_pkg.sv
// Shared helpers for the serial pattern detector: KMP failure lengths and
// the prefix-automaton transition, all evaluated at elaboration time.
package seq_det_pkg;

  localparam int unsigned MAX_PAT_W = 32;

  // Longest proper prefix of the len-bit prefix that is also its suffix.
  // The pattern is left-aligned: bit 31 is the first bit received.
  function automatic int unsigned fail_len(input logic [31:0] pattern,
                                           input int unsigned len);
    int unsigned res;
    logic        ok;
    res = 0;
    for (int unsigned k = 1; k < len; k++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < k; i++) begin
        if (pattern[5'(31 - i)] != pattern[5'(31 - (len - k) - i)]) ok = 1'b0;
      end
      if (ok) res = k;
    end
    return res;
  endfunction

  // Prefix length after accepting bit b from prefix length s (0..pat_w-1).
  // Returns pat_w on a full match; the caller chooses the restart point.
  function automatic int unsigned next_state(input logic [31:0] pattern,
                                             input int unsigned pat_w,
                                             input int unsigned s,
                                             input logic        b);
    logic [31:0] p_la;
    int unsigned k;
    int unsigned res;
    logic        done;
    p_la = pattern << (MAX_PAT_W - pat_w);
    k    = s;
    res  = 0;
    done = 1'b0;
    for (int unsigned it = 0; it <= MAX_PAT_W; it++) begin
      if (!done) begin
        if (p_la[5'(31 - k)] == b) begin
          res  = k + 1;
          done = 1'b1;
        end else if (k == 0) begin
          res  = 0;
          done = 1'b1;
        end else begin
          k = fail_len(p_la, k);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear then increment in one cycle.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_CNT = '1;

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= W'(inc);
    end else if (inc && (r_count != MAX_CNT)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with optional overlap and a
// saturating match counter; op is a registered one-cycle match pulse.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned       PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
  parameter bit                OVERLAP = 1'b1,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ip,
  input  logic                         ip_valid,
  input  logic                         clr_count,
  output logic                         op,
  output logic [CNT_W-1:0]             match_count,
  output logic [$clog2(PAT_W+1)-1:0]   state_o
);

  localparam int unsigned     ST_W    = $clog2(PAT_W + 1);
  localparam int unsigned     TAB_N   = 1 << ST_W;
  localparam logic [31:0]     PAT_32  = 32'(PATTERN);
  localparam logic [31:0]     PAT_LA  = PAT_32 << (MAX_PAT_W - PAT_W);
  localparam logic [ST_W-1:0] MATCH_S = ST_W'(PAT_W);
  localparam logic [ST_W-1:0] RESTART = OVERLAP ? ST_W'(fail_len(PAT_LA, PAT_W)) : '0;

  logic [ST_W-1:0] r_state;
  logic            r_op;
  logic [ST_W-1:0] w_state_nx;
  logic [ST_W-1:0] w_adv;
  logic            w_match;
  logic [ST_W-1:0] w_tab0 [TAB_N];
  logic [ST_W-1:0] w_tab1 [TAB_N];

  // Transition table folded to constants; unreachable prefix lengths map to 0.
  for (genvar gs = 0; gs < TAB_N; gs++) begin : g_tab
    if (gs < PAT_W) begin : g_live
      assign w_tab0[gs] = ST_W'(next_state(PAT_32, PAT_W, gs, 1'b0));
      assign w_tab1[gs] = ST_W'(next_state(PAT_32, PAT_W, gs, 1'b1));
    end else begin : g_dead
      assign w_tab0[gs] = '0;
      assign w_tab1[gs] = '0;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_match    = 1'b0;
    w_adv      = ip ? w_tab1[r_state] : w_tab0[r_state];
    if (ip_valid) begin
      if (w_adv == MATCH_S) begin
        w_match    = 1'b1;
        w_state_nx = RESTART;
      end else begin
        w_state_nx = w_adv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_op    <= w_match;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_count),
    .inc   (w_match),
    .count (match_count)
  );

  assign op      = r_op;
  assign state_o = r_state;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: several parameterisations share one
// input stream, each checked against hand-derived expectations.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset;
  logic ip;
  logic ip_valid;
  logic clr_count;

  logic       ov_op,  no_op,  sat_op,  pa_op,  pb_op;
  logic [7:0] ov_cnt, no_cnt, pa_cnt,  pb_cnt;
  logic [1:0] sat_cnt;
  logic [2:0] ov_st,  no_st;
  logic [1:0] sat_st;
  logic [0:0] pa_st,  pb_st;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .ip(ip), .ip_valid(ip_valid), .clr_count(clr_count),
    .op(ov_op), .match_count(ov_cnt), .state_o(ov_st));

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .reset(reset), .ip(ip), .ip_valid(ip_valid), .clr_count(clr_count),
    .op(no_op), .match_count(no_cnt), .state_o(no_st));

  seq_detector_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .ip(ip), .ip_valid(ip_valid), .clr_count(clr_count),
    .op(sat_op), .match_count(sat_cnt), .state_o(sat_st));

  seq_detector_param #(.PAT_W(1), .PATTERN(1'b0), .OVERLAP(1'b1), .CNT_W(8)) u_pa (
    .clk(clk), .reset(reset), .ip(ip), .ip_valid(ip_valid), .clr_count(clr_count),
    .op(pa_op), .match_count(pa_cnt), .state_o(pa_st));

  seq_detector_param #(.PAT_W(1), .PATTERN(1'b0), .OVERLAP(1'b0), .CNT_W(8)) u_pb (
    .clk(clk), .reset(reset), .ip(ip), .ip_valid(ip_valid), .clr_count(clr_count),
    .op(pb_op), .match_count(pb_cnt), .state_o(pb_st));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    ip       = b;
    ip_valid = 1'b1;
    tick();
    ip_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    ip_valid = 1'b0;
    tick();
    reset    = 1'b0;
  endtask

  initial begin
    logic [6:0] s1, e_ov, e_no;
    logic [3:0] s5, e5;
    reset     = 1'b1;
    ip        = 1'b0;
    ip_valid  = 1'b0;
    clr_count = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_op",    32'(ov_op),  32'd0);
    check("rst_cnt",   32'(ov_cnt), 32'd0);
    check("rst_state", 32'(ov_st),  32'd0);
    check("rst_sat",   32'(sat_cnt), 32'd0);
    reset = 1'b0;

    // 1011011: overlap pulses at bits 4 and 7, non-overlap at bit 4 only
    s1   = 7'b1011011;
    e_ov = 7'b0001001;
    e_no = 7'b0001000;
    for (int i = 0; i < 7; i++) begin
      bit_in(s1[6-i]);
      check($sformatf("t1_ov_op%0d", i), 32'(ov_op), 32'(e_ov[6-i]));
      check($sformatf("t1_no_op%0d", i), 32'(no_op), 32'(e_no[6-i]));
    end
    check("t1_ov_cnt",   32'(ov_cnt), 32'd2);
    check("t1_no_cnt",   32'(no_cnt), 32'd1);
    check("t1_no_state", 32'(no_st),  32'd1);
    check("t1_ov_state", 32'(ov_st),  32'd1);

    // Gap in ip_valid holds the prefix
    do_reset();
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b1);
    for (int i = 0; i < 3; i++) begin
      ip = ~ip;
      tick();
      check($sformatf("t2_gap_state%0d", i), 32'(ov_st), 32'd3);
      check($sformatf("t2_gap_op%0d", i),    32'(ov_op), 32'd0);
    end
    bit_in(1'b1);
    check("t2_op",  32'(ov_op),  32'd1);
    check("t2_cnt", 32'(ov_cnt), 32'd1);

    // Reset mid-pattern, with a would-be completing bit in the reset cycle
    do_reset();
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b1);
    reset    = 1'b1;
    ip       = 1'b1;
    ip_valid = 1'b1;
    tick();
    reset    = 1'b0;
    ip_valid = 1'b0;
    check("t3_rst_op",    32'(ov_op), 32'd0);
    check("t3_rst_state", 32'(ov_st), 32'd0);
    bit_in(1'b1);
    check("t3_op",    32'(ov_op),  32'd0);
    check("t3_state", 32'(ov_st),  32'd1);
    check("t3_cnt",   32'(ov_cnt), 32'd0);

    // Pattern 11, six ones: five pulses, counter saturates at 3
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bit_in(1'b1);
      check($sformatf("t4_op%0d", i),  32'(sat_op),  (i > 0) ? 32'd1 : 32'd0);
      check($sformatf("t4_cnt%0d", i), 32'(sat_cnt), (i > 3) ? 32'd3 : 32'(i));
    end
    clr_count = 1'b1;
    bit_in(1'b1);
    clr_count = 1'b0;
    check("t4_clr_match_cnt", 32'(sat_cnt), 32'd1);
    check("t4_clr_match_op",  32'(sat_op),  32'd1);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("t4_clr_cnt", 32'(sat_cnt), 32'd0);
    check("t4_clr_op",  32'(sat_op),  32'd0);

    // Single-bit pattern 0 on 0,1,0,0 for both overlap modes
    do_reset();
    s5 = 4'b0100;
    e5 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      bit_in(s5[3-i]);
      check($sformatf("t5_pa_op%0d", i), 32'(pa_op), 32'(e5[3-i]));
      check($sformatf("t5_pb_op%0d", i), 32'(pb_op), 32'(e5[3-i]));
    end
    check("t5_pa_cnt", 32'(pa_cnt), 32'd3);
    check("t5_pb_cnt", 32'(pb_cnt), 32'd3);
    check("t5_pa_st",  32'(pa_st),  32'd0);
    tick();
    check("t5_idle_op", 32'(pa_op), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
